instr_fetch: RTL and testbench

//  Consumer side of the PC address interface. Takes the address driven by the PC,

---
 rtl/instr_fetch_if.sv | 32 +++
 rtl/instr_fetch.sv | 148 ++++++++++++++
 tb/tb_instr_fetch.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/instr_fetch_if.sv
// ============================================================================
// instr_fetch_if : PC, memory and decoder signals around the fetch stage
// Revision 1.0
// ============================================================================
`default_nettype none

interface instr_fetch_if;
  logic [31:0] pc_addr;
  logic        fetch_en;
  logic        flush;
  logic [31:0] mem_addr;
  logic        mem_req;
  logic [31:0] mem_rdata;
  logic        mem_ack;
  logic [31:0] ir_out;
  logic        ir_valid;
  logic        ir_consume;
  logic        step_pc;
  logic        fetch_err;

  modport master (
    input  pc_addr, fetch_en, flush, mem_rdata, mem_ack, ir_consume,
    output mem_addr, mem_req, ir_out, ir_valid, step_pc, fetch_err
  );

  modport slave (
    output pc_addr, fetch_en, flush, mem_rdata, mem_ack, ir_consume,
    input  mem_addr, mem_req, ir_out, ir_valid, step_pc, fetch_err
  );
endinterface

`default_nettype wire

// File: rtl/instr_fetch.sv
// ============================================================================
// instr_fetch : fetches one word at pc_addr into the instruction register
// Revision 1.0
// ============================================================================
`default_nettype none

module instr_fetch #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic           clk,
  input  logic           rst,
  instr_fetch_if.master  bus
);

  localparam int unsigned     TIMER_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TIMER_W-1:0] c_timer_last = (TIMEOUT == 0) ? '0 : TIMER_W'(TIMEOUT - 1);
  localparam bit              c_timeout_en = (TIMEOUT != 0);

  localparam logic [1:0] c_st_idle = 2'd0;
  localparam logic [1:0] c_st_wait = 2'd1;
  localparam logic [1:0] c_st_hold = 2'd2;
  localparam logic [1:0] c_st_err  = 2'd3;

  logic [1:0]         state_q,     state_d;
  logic [31:0]        mem_addr_q,  mem_addr_d;
  logic               mem_req_q,   mem_req_d;
  logic [31:0]        ir_out_q,    ir_out_d;
  logic               ir_valid_q,  ir_valid_d;
  logic               step_pc_q,   step_pc_d;
  logic               fetch_err_q, fetch_err_d;
  logic [TIMER_W-1:0] timer_q,     timer_d;

  logic w_timeout_hit;

  assign w_timeout_hit = c_timeout_en && (timer_q == c_timer_last);

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= c_st_idle;
      mem_addr_q  <= '0;
      mem_req_q   <= 1'b0;
      ir_out_q    <= '0;
      ir_valid_q  <= 1'b0;
      step_pc_q   <= 1'b0;
      fetch_err_q <= 1'b0;
      timer_q     <= '0;
    end else begin
      state_q     <= state_d;
      mem_addr_q  <= mem_addr_d;
      mem_req_q   <= mem_req_d;
      ir_out_q    <= ir_out_d;
      ir_valid_q  <= ir_valid_d;
      step_pc_q   <= step_pc_d;
      fetch_err_q <= fetch_err_d;
      timer_q     <= timer_d;
    end
  end

  // Next-state logic; flush wins over ack and consume in every non-error state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      c_st_idle: begin
        if (!bus.flush && bus.fetch_en) state_d = c_st_wait;
      end
      c_st_wait: begin
        if (bus.flush)            state_d = c_st_idle;
        else if (bus.mem_ack)     state_d = c_st_hold;
        else if (w_timeout_hit)   state_d = c_st_err;
      end
      c_st_hold: begin
        if (bus.flush)            state_d = c_st_idle;
        else if (bus.ir_consume)  state_d = bus.fetch_en ? c_st_wait : c_st_idle;
      end
      c_st_err: state_d = c_st_err;
      default:  state_d = c_st_idle;
    endcase
  end

  // Registered output next values
  always_comb begin
    mem_addr_d  = mem_addr_q;
    mem_req_d   = mem_req_q;
    ir_out_d    = ir_out_q;
    ir_valid_d  = ir_valid_q;
    step_pc_d   = 1'b0;
    fetch_err_d = fetch_err_q;
    timer_d     = timer_q;
    unique case (state_q)
      c_st_idle: begin
        if (bus.flush) begin
          mem_req_d  = 1'b0;
          ir_valid_d = 1'b0;
        end else if (bus.fetch_en) begin
          mem_addr_d = bus.pc_addr;
          mem_req_d  = 1'b1;
          timer_d    = '0;
        end
      end
      c_st_wait: begin
        if (bus.flush) begin
          mem_req_d  = 1'b0;
          ir_valid_d = 1'b0;
        end else if (bus.mem_ack) begin
          ir_out_d   = bus.mem_rdata;
          ir_valid_d = 1'b1;
          mem_req_d  = 1'b0;
          step_pc_d  = 1'b1;
        end else begin
          timer_d = timer_q + TIMER_W'(1);
          if (w_timeout_hit) begin
            mem_req_d   = 1'b0;
            fetch_err_d = 1'b1;
          end
        end
      end
      c_st_hold: begin
        if (bus.flush) begin
          mem_req_d  = 1'b0;
          ir_valid_d = 1'b0;
        end else if (bus.ir_consume) begin
          ir_valid_d = 1'b0;
          if (bus.fetch_en) begin
            mem_addr_d = bus.pc_addr;
            mem_req_d  = 1'b1;
            timer_d    = '0;
          end
        end
      end
      c_st_err: mem_req_d = 1'b0;
      default: begin
        mem_req_d  = 1'b0;
        ir_valid_d = 1'b0;
      end
    endcase
  end

  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_req   = mem_req_q;
  assign bus.ir_out    = ir_out_q;
  assign bus.ir_valid  = ir_valid_q;
  assign bus.step_pc   = step_pc_q;
  assign bus.fetch_err = fetch_err_q;

endmodule

`default_nettype wire

// File: tb/tb_instr_fetch.sv
// ============================================================================
// tb_instr_fetch : directed self-checking bench for instr_fetch
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_instr_fetch;

  logic clk;
  logic rst;
  int   total;
  int   bad;
  int   steps;
  logic [31:0] pc;

  instr_fetch_if bus ();

  instr_fetch #(.TIMEOUT(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    bus.pc_addr    = '0;
    bus.fetch_en   = 1'b0;
    bus.flush      = 1'b0;
    bus.mem_rdata  = '0;
    bus.mem_ack    = 1'b0;
    bus.ir_consume = 1'b0;
    tick();
    tick();
    chk("rst_mem_addr",  bus.mem_addr,  32'h0);
    chk("rst_mem_req",   {31'b0, bus.mem_req},   32'h0);
    chk("rst_ir_out",    bus.ir_out,    32'h0);
    chk("rst_ir_valid",  {31'b0, bus.ir_valid},  32'h0);
    chk("rst_step_pc",   {31'b0, bus.step_pc},   32'h0);
    chk("rst_fetch_err", {31'b0, bus.fetch_err}, 32'h0);

    // 1: single fetch, ack one cycle after request
    rst = 1'b0;
    bus.fetch_en = 1'b1;
    bus.pc_addr  = 32'h100;
    tick();
    chk("t1_mem_addr", bus.mem_addr, 32'h100);
    chk("t1_mem_req",  {31'b0, bus.mem_req}, 32'h1);
    bus.fetch_en  = 1'b0;
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = 32'hDEADBEEF;
    tick();
    chk("t1_ir_out",   bus.ir_out, 32'hDEADBEEF);
    chk("t1_ir_valid", {31'b0, bus.ir_valid}, 32'h1);
    chk("t1_step_hi",  {31'b0, bus.step_pc},  32'h1);
    chk("t1_req_lo",   {31'b0, bus.mem_req},  32'h0);
    bus.mem_ack = 1'b0;
    tick();
    chk("t1_step_lo",  {31'b0, bus.step_pc},  32'h0);
    chk("t1_hold_vld", {31'b0, bus.ir_valid}, 32'h1);
    bus.ir_consume = 1'b1;
    tick();
    chk("t1_consumed", {31'b0, bus.ir_valid}, 32'h0);
    chk("t1_no_req",   {31'b0, bus.mem_req},  32'h0);

    // 2: three back-to-back fetches, ack after two wait cycles, PC model +4
    pc = 32'h0;
    bus.pc_addr  = pc;
    bus.fetch_en = 1'b1;
    steps = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("t2_addr%0d", i), bus.mem_addr, pc);
      chk($sformatf("t2_req%0d", i), {31'b0, bus.mem_req}, 32'h1);
      chk($sformatf("t2_nostep%0d", i), {31'b0, bus.step_pc}, 32'h0);
      for (int w = 0; w < 2; w++) begin
        tick();
        chk($sformatf("t2_stable%0d_%0d", i, w), bus.mem_addr, pc);
        chk($sformatf("t2_reqhold%0d_%0d", i, w), {31'b0, bus.mem_req}, 32'h1);
      end
      bus.mem_ack   = 1'b1;
      bus.mem_rdata = 32'hA000_0000 + i;
      tick();
      bus.mem_ack = 1'b0;
      if (bus.step_pc === 1'b1) steps++;
      chk($sformatf("t2_ir%0d", i), bus.ir_out, 32'hA000_0000 + i);
      pc = pc + 32'h4;
      bus.pc_addr = pc;
    end
    chk("t2_step_count", steps, 32'd3);
    bus.fetch_en = 1'b0;
    tick();
    chk("t2_idle_vld", {31'b0, bus.ir_valid}, 32'h0);
    chk("t2_idle_req", {31'b0, bus.mem_req},  32'h0);
    bus.ir_consume = 1'b0;

    // 3: timeout with no ack
    bus.pc_addr  = 32'h200;
    bus.fetch_en = 1'b1;
    tick();
    bus.fetch_en = 1'b0;
    for (int c = 0; c < 15; c++) tick();
    chk("t3_err_early", {31'b0, bus.fetch_err}, 32'h0);
    chk("t3_req_early", {31'b0, bus.mem_req},   32'h1);
    tick();
    chk("t3_err",   {31'b0, bus.fetch_err}, 32'h1);
    chk("t3_req0",  {31'b0, bus.mem_req},   32'h0);
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = 32'h77777777;
    bus.flush     = 1'b1;
    bus.fetch_en  = 1'b1;
    tick();
    tick();
    chk("t3_err_sticky", {31'b0, bus.fetch_err}, 32'h1);
    chk("t3_err_req",    {31'b0, bus.mem_req},   32'h0);
    chk("t3_err_step",   {31'b0, bus.step_pc},   32'h0);
    chk("t3_err_addr",   bus.mem_addr, 32'h200);
    chk("t3_err_ir",     bus.ir_out,   32'hA000_0002);
    bus.mem_ack  = 1'b0;
    bus.flush    = 1'b0;
    bus.fetch_en = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t3_rst_err",  {31'b0, bus.fetch_err}, 32'h0);
    chk("t3_rst_addr", bus.mem_addr, 32'h0);

    // 4: flush and ack on the same edge
    bus.pc_addr  = 32'h300;
    bus.fetch_en = 1'b1;
    tick();
    bus.fetch_en  = 1'b0;
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = 32'h12345678;
    bus.flush     = 1'b1;
    tick();
    bus.mem_ack = 1'b0;
    bus.flush   = 1'b0;
    chk("t4_vld",  {31'b0, bus.ir_valid}, 32'h0);
    chk("t4_step", {31'b0, bus.step_pc},  32'h0);
    chk("t4_req",  {31'b0, bus.mem_req},  32'h0);
    chk("t4_ir",   bus.ir_out, 32'h0);
    tick();
    chk("t4_idle", {31'b0, bus.mem_req}, 32'h0);
    bus.fetch_en = 1'b1;
    tick();
    chk("t4_refetch_addr", bus.mem_addr, 32'h300);
    chk("t4_refetch_req",  {31'b0, bus.mem_req}, 32'h1);

    // 5: long hold without consume
    bus.fetch_en  = 1'b0;
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = 32'hCAFEF00D;
    tick();
    bus.mem_ack = 1'b0;
    steps = (bus.step_pc === 1'b1) ? 1 : 0;
    for (int c = 0; c < 10; c++) begin
      tick();
      if (bus.step_pc === 1'b1) steps++;
    end
    chk("t5_steps", steps, 32'd1);
    chk("t5_vld",   {31'b0, bus.ir_valid}, 32'h1);
    chk("t5_req",   {31'b0, bus.mem_req},  32'h0);
    chk("t5_ir",    bus.ir_out, 32'hCAFEF00D);
    bus.ir_consume = 1'b1;
    tick();
    bus.ir_consume = 1'b0;
    chk("t5_cons_vld", {31'b0, bus.ir_valid}, 32'h0);
    tick();
    chk("t5_idle_req", {31'b0, bus.mem_req}, 32'h0);

    // 6: reset in the middle of a wait
    bus.pc_addr  = 32'h400;
    bus.fetch_en = 1'b1;
    tick();
    bus.fetch_en = 1'b0;
    tick();
    chk("t6_wait_req", {31'b0, bus.mem_req}, 32'h1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t6_addr", bus.mem_addr, 32'h0);
    chk("t6_req",  {31'b0, bus.mem_req},  32'h0);
    chk("t6_ir",   bus.ir_out, 32'h0);
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = 32'h55;
    tick();
    bus.mem_ack = 1'b0;
    chk("t6_stray_vld",  {31'b0, bus.ir_valid}, 32'h0);
    chk("t6_stray_step", {31'b0, bus.step_pc},  32'h0);
    chk("t6_stray_ir",   bus.ir_out, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
